// File: rtl/a5_keystream_gen.sv
// A5/1-family keystream generator: parallel key/frame load, mix, valid/ready beats.
// Define A5_RESYNC_EN for frame-only resync from a post-key-load LFSR snapshot.
module a5_keystream_gen #(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int MIX_CYCLES = 100,
    parameter int OUT_W      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  resync,
    output logic                  busy,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic [OUT_W-1:0]      ks_data
);

    localparam int KF_MAX  = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int CNT_MAX = (KF_MAX > MIX_CYCLES) ? KF_MAX : MIX_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        RUN
    } state_t;

    state_t state, state_nx;

    logic [18:0] r1, r1_ld, r1_mj;
    logic [21:0] r2, r2_ld, r2_mj;
    logic [22:0] r3, r3_ld, r3_mj;

    logic [KEY_BITS-1:0]   key_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bcnt;
    logic [OUT_W-1:0]      coll, beat;

    logic maj, z, ld_bit, fb1, fb2, fb3;
    logic key_last, frame_last, mix_last, beat_last;
    logic do_resync;

    assign fb1 = r1[13] ^ r1[16] ^ r1[17] ^ r1[18];
    assign fb2 = r2[20] ^ r2[21];
    assign fb3 = r3[7] ^ r3[20] ^ r3[21] ^ r3[22];
    assign maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    assign z   = r1[18] ^ r2[21] ^ r3[22];

    // Load steps clock all three registers with the serial input mixed in.
    assign ld_bit = (state == LOAD_KEY) ? key_q[0] : frame_q[0];
    assign r1_ld  = {r1[17:0], fb1 ^ ld_bit};
    assign r2_ld  = {r2[20:0], fb2 ^ ld_bit};
    assign r3_ld  = {r3[21:0], fb3 ^ ld_bit};

    assign r1_mj = (r1[8] == maj) ? {r1[17:0], fb1} : r1;
    assign r2_mj = (r2[10] == maj) ? {r2[20:0], fb2} : r2;
    assign r3_mj = (r3[10] == maj) ? {r3[21:0], fb3} : r3;

    assign key_last   = (cnt == CW'(KEY_BITS - 1));
    assign frame_last = (cnt == CW'(FRAME_BITS - 1));
    assign mix_last   = (cnt == CW'(MIX_CYCLES - 1));
    assign beat_last  = (bcnt == BW'(OUT_W - 1));
    assign beat       = (coll << 1) | OUT_W'(z);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = LOAD_KEY;
        end else if (do_resync) begin
            state_nx = LOAD_FRAME;
        end else begin
            unique case (state)
                LOAD_KEY:   if (key_last)   state_nx = LOAD_FRAME;
                LOAD_FRAME: if (frame_last) state_nx = MIX;
                MIX:        if (mix_last)   state_nx = RUN;
                default:    state_nx = state;
            endcase
        end
    end

    always_comb begin
        busy = (state == LOAD_KEY) || (state == LOAD_FRAME) || (state == MIX);
    end

`ifdef A5_RESYNC_EN
    logic [18:0] s1;
    logic [21:0] s2;
    logic [22:0] s3;
    logic        snap_ok;

    assign do_resync = resync && snap_ok;

    // Snapshot captures the key-only state, i.e. the result of the last key step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            snap_ok <= 1'b0;
        end else if (start) begin
            snap_ok <= 1'b0;
        end else if (state == LOAD_KEY && key_last) begin
            s1      <= r1_ld;
            s2      <= r2_ld;
            s3      <= r3_ld;
            snap_ok <= 1'b1;
        end
    end
`else
    logic unused_resync;

    assign unused_resync = resync;
    assign do_resync     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            key_q    <= '0;
            frame_q  <= '0;
            cnt      <= '0;
            bcnt     <= '0;
            coll     <= '0;
            ks_valid <= 1'b0;
            ks_data  <= '0;
        end else if (start) begin
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            key_q    <= key;
            frame_q  <= frame;
            cnt      <= '0;
            bcnt     <= '0;
            coll     <= '0;
            ks_valid <= 1'b0;
        end else if (do_resync) begin
`ifdef A5_RESYNC_EN
            r1 <= s1;
            r2 <= s2;
            r3 <= s3;
`endif
            frame_q  <= frame;
            cnt      <= '0;
            bcnt     <= '0;
            coll     <= '0;
            ks_valid <= 1'b0;
        end else begin
            if (ks_valid && ks_ready) ks_valid <= 1'b0;
            unique case (state)
                LOAD_KEY: begin
                    r1    <= r1_ld;
                    r2    <= r2_ld;
                    r3    <= r3_ld;
                    key_q <= key_q >> 1;
                    cnt   <= key_last ? '0 : cnt + 1'b1;
                end
                LOAD_FRAME: begin
                    r1      <= r1_ld;
                    r2      <= r2_ld;
                    r3      <= r3_ld;
                    frame_q <= frame_q >> 1;
                    cnt     <= frame_last ? '0 : cnt + 1'b1;
                end
                MIX: begin
                    r1  <= r1_mj;
                    r2  <= r2_mj;
                    r3  <= r3_mj;
                    cnt <= mix_last ? '0 : cnt + 1'b1;
                end
                RUN: begin
                    // Only the beat-completing step can stall on a pending beat.
                    if (!beat_last) begin
                        r1   <= r1_mj;
                        r2   <= r2_mj;
                        r3   <= r3_mj;
                        coll <= beat;
                        bcnt <= bcnt + 1'b1;
                    end else if (!ks_valid || ks_ready) begin
                        r1       <= r1_mj;
                        r2       <= r2_mj;
                        r3       <= r3_mj;
                        coll     <= '0;
                        bcnt     <= '0;
                        ks_data  <= beat;
                        ks_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_a5_keystream_gen.sv
// Bench for a5_keystream_gen: OUT_W=1 and OUT_W=8 instances against a reference model.
// Covers latency, stream contents, backpressure, restart, reset and resync.
module tb_a5_keystream_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        resync = 1'b0;
    logic        rdy1 = 1'b0;
    logic        rdy8 = 1'b0;
    logic [63:0] key = '0;
    logic [21:0] frame = '0;
    logic        busy1, busy8, v1, v8;
    logic [0:0]  d1;
    logic [7:0]  d8;

    always #5 clk = ~clk;

    a5_keystream_gen #(.OUT_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .key(key), .frame(frame),
        .resync(resync), .busy(busy1), .ks_valid(v1), .ks_ready(rdy1),
        .ks_data(d1)
    );

    a5_keystream_gen #(.OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .key(key), .frame(frame),
        .resync(resync), .busy(busy8), .ks_valid(v8), .ks_ready(rdy8),
        .ks_data(d8)
    );

    typedef struct {
        logic [63:0] key;
        logic [21:0] frame;
        int          nbits;
        int          lat;
        int          busy_n;
    } vec_t;

    vec_t        tbl[4];
    int          tests = 0;
    int          fails = 0;
    int          got1 = 0;
    int          got8 = 0;
    bit          q1[$];
    bit          q8[$];
    int unsigned rv[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: reference stream exhausted", nm);
    endtask

    // Reference model: registers as integers, feedback = parity of tapped bits.
    function automatic int unsigned len_of(input int i);
        case (i)
            0:       return 19;
            1:       return 22;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned tap_of(input int i);
        case (i)
            0:       return 32'h0007_2000;
            1:       return 32'h0030_0000;
            default: return 32'h0070_0080;
        endcase
    endfunction

    function automatic int unsigned clkbit_of(input int i);
        return (i == 0) ? 8 : 10;
    endfunction

    function automatic void clock_reg(input int i, input bit inb);
        bit fb;
        fb = (^(rv[i] & tap_of(i))) ^ inb;
        rv[i] = ((rv[i] << 1) | 32'(fb)) & ((32'd1 << len_of(i)) - 1);
    endfunction

    function automatic void maj_step();
        bit c[3];
        int votes = 0;
        bit m;
        for (int i = 0; i < 3; i++) begin
            c[i] = 1'(rv[i] >> clkbit_of(i));
            votes += int'(c[i]);
        end
        m = (votes >= 2);
        for (int i = 0; i < 3; i++)
            if (c[i] == m) clock_reg(i, 1'b0);
    endfunction

    function automatic void run_model(input logic [63:0] k, input logic [21:0] f, input int n);
        bit zb;
        q1.delete();
        q8.delete();
        for (int i = 0; i < 3; i++) rv[i] = 0;
        for (int j = 0; j < 64; j++)
            for (int i = 0; i < 3; i++) clock_reg(i, k[j]);
        for (int j = 0; j < 22; j++)
            for (int i = 0; i < 3; i++) clock_reg(i, f[j]);
        for (int j = 0; j < 100; j++) maj_step();
        for (int j = 0; j < n; j++) begin
            zb = 1'b0;
            for (int i = 0; i < 3; i++) zb ^= 1'(rv[i] >> (len_of(i) - 1));
            q1.push_back(zb);
            q8.push_back(zb);
            maj_step();
        end
    endfunction

    task automatic tick(input bit en1, input bit en8);
        logic [7:0] e8;
        rdy1 = en1;
        rdy8 = en8 ? 1'($urandom_range(0, 1)) : 1'b0;
        if (v1 && rdy1) begin
            if (q1.size() == 0) fail("bit1");
            else chk("bit1", 64'(d1), 64'(q1.pop_front()));
            got1++;
        end
        if (v8 && rdy8) begin
            e8 = '0;
            if (q8.size() < 8) fail("beat8");
            else begin
                for (int b = 0; b < 8; b++) e8 = {e8[6:0], q8.pop_front()};
                chk("beat8", 64'(d8), 64'(e8));
            end
            got8++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic collect(input int n);
        int guard = 0;
        while ((got1 < n || got8 < n / 8) && guard < 8000) begin
            tick(got1 < n, got8 < n / 8);
            guard++;
        end
        chk("collect_done", 64'(got1 >= n && got8 >= n / 8), 64'd1);
    endtask

    task automatic do_start(input logic [63:0] k, input logic [21:0] f);
        rdy1 = 1'b0;
        rdy8 = 1'b0;
        start = 1'b1;
        key = k;
        frame = f;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        key = {$urandom, $urandom};
        frame = 22'($urandom);
        got1 = 0;
        got8 = 0;
    endtask

    task automatic wait_first(input string nm, input int lat, input int bn);
        int e = 0;
        int bc = 0;
        bit seen = 1'b0;
        rdy1 = 1'b0;
        rdy8 = 1'b0;
        while (!seen && e < 600) begin
            if (v1) seen = 1'b1;
            else begin
                if (busy1) bc++;
                @(posedge clk);
                e++;
                @(negedge clk);
            end
        end
        chk({nm, "_latency"}, 64'(e), 64'(lat));
        chk({nm, "_busy_cycles"}, 64'(bc), 64'(bn));
    endtask

    initial begin
        bit          hold_ok;
        logic [63:0] k6;
        logic [21:0] f6a, f6b;

        tbl[0].key = 64'h0;
        tbl[0].frame = 22'h0;
        tbl[0].nbits = 1000;
        tbl[1].key = 64'h1223456789ABCDEF;
        tbl[1].frame = 22'h134;
        tbl[1].nbits = 228;
        tbl[2].key = {$urandom, $urandom};
        tbl[2].frame = 22'($urandom);
        tbl[2].nbits = 300;
        tbl[3].key = {$urandom, $urandom};
        tbl[3].frame = 22'($urandom);
        tbl[3].nbits = 160;
        for (int v = 0; v < 4; v++) begin
            tbl[v].lat = 187;
            tbl[v].busy_n = 186;
        end

        #1 rst = 1'b1;
        #1;
        chk("rst_valid1", 64'(v1), 64'd0);
        chk("rst_data1", 64'(d1), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_valid8", 64'(v8), 64'd0);
        chk("rst_data8", 64'(d8), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy1), 64'd0);

        for (int v = 0; v < 4; v++) begin
            run_model(tbl[v].key, tbl[v].frame, tbl[v].nbits + 200);
            do_start(tbl[v].key, tbl[v].frame);
            wait_first("start", tbl[v].lat, tbl[v].busy_n);
            collect(tbl[v].nbits);
            if (v == 1) begin
                hold_ok = 1'b1;
                for (int c = 0; c < 50; c++) begin
                    if (!(v1 === 1'b1 && q1.size() > 0 && d1[0] === q1[0]))
                        hold_ok = 1'b0;
                    tick(1'b0, 1'b0);
                end
                chk("hold_50", 64'(hold_ok), 64'd1);
                collect(tbl[v].nbits + 64);
            end
        end

        chk("pending_before_restart", 64'(v1), 64'd1);
        run_model(tbl[2].key, tbl[2].frame, 10);
        do_start(tbl[2].key, tbl[2].frame);
        chk("restart_valid1", 64'(v1), 64'd0);
        chk("restart_valid8", 64'(v8), 64'd0);
        repeat (120) @(posedge clk);
        @(negedge clk);
        chk("mix_busy", 64'(busy1), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_valid1", 64'(v1), 64'd0);
        chk("midrst_data1", 64'(d1), 64'd0);
        chk("midrst_busy1", 64'(busy1), 64'd0);
        chk("midrst_busy8", 64'(busy8), 64'd0);
        chk("midrst_data8", 64'(d8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle_busy", 64'(busy1), 64'd0);
        chk("post_rst_idle_valid", 64'(v1), 64'd0);

        k6 = {$urandom, $urandom};
        f6a = 22'($urandom);
        f6b = f6a ^ 22'h15A5A;
        run_model(k6, f6a, 440);
        do_start(k6, f6a);
        wait_first("r6_start", 187, 186);
        collect(40);
        rdy1 = 1'b0;
        rdy8 = 1'b0;
        resync = 1'b1;
        frame = f6b;
        @(posedge clk);
        @(negedge clk);
        resync = 1'b0;
        frame = 22'($urandom);
`ifdef A5_RESYNC_EN
        chk("resync_valid1", 64'(v1), 64'd0);
        run_model(k6, f6b, 400);
        got1 = 0;
        got8 = 0;
        wait_first("resync", 123, 122);
        collect(200);
`else
        chk("resync_ignored_valid", 64'(v1), 64'd1);
        chk("resync_ignored_busy", 64'(busy1), 64'd0);
        collect(240);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
